// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   state_e           : FSM state encoding (ST_INIT, ST_FETCH, ST_ISSUE, ST_HALT).
//   DEFAULT_RESET_VEC : default address loaded into the PC after reset.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_RESET_VEC = 0;

endpackage

// File: rtl/fetch_seq_if.sv
// Handshake bundle between the fetch sequencer and its neighbours.
//   mem_*   : instruction memory read (req/ack, ack is a one-cycle data strobe)
//   instr_* : instruction hand-off to decode (valid/ready)
//   br_*    : branch redirect from execute (valid held until ack)
// master = fetch_seq side, slave = memory/decode/execute side.
interface fetch_seq_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned IWIDTH = 8
) ();

    logic              mem_req;
    logic [WIDTH-1:0]  mem_adr;
    logic              mem_ack;
    logic [IWIDTH-1:0] mem_rdata;

    logic              instr_valid;
    logic [IWIDTH-1:0] instr_data;
    logic [WIDTH-1:0]  instr_adr;
    logic              instr_ready;

    logic              br_valid;
    logic [WIDTH-1:0]  br_target;
    logic              br_ack;

    modport master (
        output mem_req, mem_adr,
        input  mem_ack, mem_rdata,
        output instr_valid, instr_data, instr_adr,
        input  instr_ready,
        input  br_valid, br_target,
        output br_ack
    );

    modport slave (
        input  mem_req, mem_adr,
        output mem_ack, mem_rdata,
        input  instr_valid, instr_data, instr_adr,
        output instr_ready,
        output br_valid, br_target,
        input  br_ack
    );

endinterface

// File: rtl/fetch_timer.sv
// Fetch timeout counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the count (state entry or mem_ack)
//   run          : count this cycle
//   expired      : this is the TIMEOUT-th counted cycle since the last clear
module fetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = run && !clear && (count_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: drives the PC control inputs, fetches one word per PC
// value over mem req/ack, presents it to decode over valid/ready and accepts branch
// redirects from execute.
//   clk, reset_n        : clock, asynchronous active-low reset
//   run                 : fetch enable; low drains to HALT
//   pc_adr              : current PC value
//   pc_enable / pc_load : PC increment / load requests (load wins, never both)
//   pc_nxt_adr          : PC load value
//   halted              : high in HALT
//   fetch_err           : sticky fetch timeout flag
//   bus                 : mem / instr / br handshakes (fetch_seq_if.master)
// Optional build macro FETCH_TIMEOUT_EN adds a fetch timeout (fetch_timer).
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned IWIDTH    = 8,
    parameter int unsigned RESET_VEC = DEFAULT_RESET_VEC,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [WIDTH-1:0] pc_adr,
    output logic             pc_enable,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_nxt_adr,
    output logic             halted,
    output logic             fetch_err,
    fetch_seq_if.master      bus
);

    localparam logic [WIDTH-1:0] ResetAdr = WIDTH'(RESET_VEC);

    state_e            state_q, state_d;
    logic [IWIDTH-1:0] instr_data_q, instr_data_d;
    logic [WIDTH-1:0]  instr_adr_q, instr_adr_d;
    logic              timer_expired;
    logic              timeout_hit;
    logic              err_q;

    always_comb begin
        state_d         = state_q;
        instr_data_d    = instr_data_q;
        instr_adr_d     = instr_adr_q;
        pc_enable       = 1'b0;
        pc_load         = 1'b0;
        pc_nxt_adr      = ResetAdr;
        bus.mem_req     = 1'b0;
        bus.instr_valid = 1'b0;
        bus.br_ack      = 1'b0;
        halted          = 1'b0;
        timeout_hit     = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                // State is forced to INIT while reset is held; keep pc_load quiet then.
                pc_load = reset_n;
                state_d = run ? ST_FETCH : ST_HALT;
            end
            ST_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    if (bus.br_valid) begin
                        // Redirect: drop the returned word and re-request at the target.
                        pc_load    = 1'b1;
                        pc_nxt_adr = bus.br_target;
                        bus.br_ack = 1'b1;
                    end else begin
                        instr_data_d = bus.mem_rdata;
                        instr_adr_d  = pc_adr;
                        state_d      = ST_ISSUE;
                    end
                end else if (timer_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            ST_ISSUE: begin
                bus.instr_valid = 1'b1;
                if (bus.br_valid) begin
                    pc_load    = 1'b1;
                    pc_nxt_adr = bus.br_target;
                    bus.br_ack = 1'b1;
                    state_d    = run ? ST_FETCH : ST_HALT;
                end else if (bus.instr_ready) begin
                    pc_enable = 1'b1;
                    state_d   = run ? ST_FETCH : ST_HALT;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (bus.br_valid) begin
                    pc_load    = 1'b1;
                    pc_nxt_adr = bus.br_target;
                    bus.br_ack = 1'b1;
                end
                // A timeout pins the sequencer here until reset.
                if (run && !err_q) begin
                    state_d = ST_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            instr_data_q <= '0;
            instr_adr_q  <= '0;
        end else begin
            state_q      <= state_d;
            instr_data_q <= instr_data_d;
            instr_adr_q  <= instr_adr_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic timer_clear;
    logic err_d;

    assign timer_clear = (state_q != ST_FETCH) || bus.mem_ack;
    assign err_d       = err_q || timeout_hit;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .run     (state_q == ST_FETCH),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign timer_expired = 1'b0;
    assign err_q         = 1'b0;
`endif

    assign fetch_err      = err_q;
    assign bus.mem_adr    = pc_adr;
    assign bus.instr_data = instr_data_q;
    assign bus.instr_adr  = instr_adr_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a small PC register model drives pc_adr; memory,
// decode and execute responses are driven step by step from one initial block.
module tb_fetch_seq;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned IWIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             run;
    logic [WIDTH-1:0] pc_q;
    logic             pc_enable;
    logic             pc_load;
    logic [WIDTH-1:0] pc_nxt_adr;
    logic             halted;
    logic             fetch_err;

    int tests_run;
    int tests_failed;

    fetch_seq_if #(.WIDTH(WIDTH), .IWIDTH(IWIDTH)) bus ();

    fetch_seq #(
        .WIDTH     (WIDTH),
        .IWIDTH    (IWIDTH),
        .RESET_VEC (32'h10),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .pc_adr     (pc_q),
        .pc_enable  (pc_enable),
        .pc_load    (pc_load),
        .pc_nxt_adr (pc_nxt_adr),
        .halted     (halted),
        .fetch_err  (fetch_err),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC block stand-in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else if (pc_load) begin
            pc_q <= pc_nxt_adr;
        end else if (pc_enable) begin
            pc_q <= pc_q + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // From the first FETCH cycle: wait, ack with data, check ISSUE, leave ISSUE.
    task automatic fetch_one(input logic [7:0] adr, input logic [7:0] data, input int wait_cyc);
        check("fetch_req", {31'd0, bus.mem_req}, 32'd1);
        check("fetch_adr", {24'd0, bus.mem_adr}, {24'd0, adr});
        repeat (wait_cyc) step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
        #1;
        check("ack_no_pc_change", {30'd0, pc_load, pc_enable}, 32'd0);
        step();
        bus.mem_ack = 1'b0;
        #1;
        check("issue_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("issue_data", {24'd0, bus.instr_data}, {24'd0, data});
        check("issue_adr", {24'd0, bus.instr_adr}, {24'd0, adr});
        check("issue_pc_enable", {31'd0, pc_enable}, {31'd0, bus.instr_ready});
        step();
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        reset_n         = 1'b0;
        run             = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        bus.instr_ready = 1'b0;
        bus.br_valid    = 1'b0;
        bus.br_target   = '0;
        #2;
        // Reset state
        check("rst_outputs", {26'd0, pc_load, pc_enable, bus.mem_req, bus.instr_valid,
                              bus.br_ack, halted}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        check("rst_instr", {16'd0, bus.instr_data, bus.instr_adr}, 32'd0);
        check("rst_nxt_adr", {24'd0, pc_nxt_adr}, 32'h10);

        // 1: sequential fetches from the reset vector
        run             = 1'b1;
        bus.instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        check("init_load", {31'd0, pc_load}, 32'd1);
        check("init_nxt_adr", {24'd0, pc_nxt_adr}, 32'h10);
        check("init_no_req", {31'd0, bus.mem_req}, 32'd0);
        step();
        fetch_one(8'h10, 8'hA0, 1);
        fetch_one(8'h11, 8'hA1, 1);
        fetch_one(8'h12, 8'hA2, 1);

        // 3: branch held through FETCH, accepted only with the ack
        bus.br_valid  = 1'b1;
        bus.br_target = 8'h20;
        #1;
        check("br_wait_ack", {31'd0, bus.br_ack}, 32'd0);
        step();
        check("br_wait_ack2", {30'd0, bus.br_ack, pc_load}, 32'd0);
        step();
        check("br_wait_ack3", {30'd0, bus.br_ack, pc_load}, 32'd0);
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hEE;
        #1;
        check("br_fetch_ack", {30'd0, bus.br_ack, pc_load}, 32'd3);
        check("br_fetch_tgt", {24'd0, pc_nxt_adr}, 32'h20);
        step();
        bus.mem_ack  = 1'b0;
        bus.br_valid = 1'b0;
        #1;
        check("br_fetch_dropped", {31'd0, bus.instr_valid}, 32'd0);
        check("br_refetch_adr", {23'd0, bus.mem_req, bus.mem_adr}, 32'h120);

        // 2: branch in ISSUE with decode stalled drops the instruction
        bus.instr_ready = 1'b0;
        fetch_one(8'h20, 8'h55, 0);
        // fetch_one stepped once more; still in ISSUE and holding
        check("issue_hold", {15'd0, bus.instr_valid, bus.instr_data, bus.instr_adr}, 32'h15520);
        bus.br_valid  = 1'b1;
        bus.br_target = 8'h40;
        #1;
        check("issue_br", {29'd0, bus.br_ack, pc_load, pc_enable}, 32'd6);
        check("issue_br_tgt", {24'd0, pc_nxt_adr}, 32'h40);
        step();
        bus.br_valid = 1'b0;
        #1;
        check("issue_br_after", {23'd0, bus.instr_valid, bus.mem_adr}, 32'h040);
        check("issue_br_req", {31'd0, bus.mem_req}, 32'd1);

        // 4: redirect to 0xFF, wrap to 0x00, then drain to HALT
        bus.instr_ready = 1'b1;
        bus.br_valid    = 1'b1;
        bus.br_target   = 8'hFF;
        bus.mem_ack     = 1'b1;
        step();
        bus.br_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        fetch_one(8'hFF, 8'h77, 0);
        check("wrap_adr", {24'd0, bus.mem_adr}, 32'h00);
        run = 1'b0;
        fetch_one(8'h00, 8'h88, 1);
        check("halt_state", {29'd0, halted, bus.mem_req, bus.instr_valid}, 32'd4);
        step();
        check("halt_stay", {30'd0, halted, bus.mem_req}, 32'd2);
        bus.br_valid  = 1'b1;
        bus.br_target = 8'h30;
        #1;
        check("halt_br", {30'd0, bus.br_ack, pc_load}, 32'd3);
        step();
        bus.br_valid = 1'b0;
        #1;
        check("halt_br_after", {31'd0, halted}, 32'd1);

        // 5: asynchronous reset in the middle of a fetch
        run = 1'b1;
        step();
        check("resume_adr", {23'd0, bus.mem_req, bus.mem_adr}, 32'h130);
        bus.mem_ack   = 1'b1;
        bus.br_valid  = 1'b1;
        bus.br_target = 8'h50;
        #1;
        check("pre_rst_ack", {31'd0, bus.br_ack}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst", {28'd0, bus.mem_req, bus.instr_valid, bus.br_ack, pc_load}, 32'd0);
        check("async_rst_instr", {16'd0, bus.instr_data, bus.instr_adr}, 32'd0);
        bus.mem_ack  = 1'b0;
        bus.br_valid = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        check("rst2_init", {23'd0, pc_load, pc_nxt_adr}, 32'h110);
        step();
        check("rst2_fetch", {23'd0, bus.mem_req, bus.mem_adr}, 32'h110);

        // 6: no ack at all; first FETCH cycle is the current one
        repeat (15) step();
        check("to_before", {30'd0, fetch_err, bus.mem_req}, 32'd1);
        step();
`ifdef FETCH_TIMEOUT_EN
        check("to_err", {29'd0, fetch_err, halted, bus.mem_req}, 32'd6);
        repeat (3) step();
        check("to_sticky", {29'd0, fetch_err, halted, bus.mem_req}, 32'd6);
        reset_n = 1'b0;
        #1;
        check("to_rst_clear", {31'd0, fetch_err}, 32'd0);
        reset_n = 1'b1;
`else
        check("no_to_err", {29'd0, fetch_err, halted, bus.mem_req}, 32'd1);
        repeat (20) step();
        check("no_to_wait", {29'd0, fetch_err, halted, bus.mem_req}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction-fetch sequencer that owns the program counter's control inputs (enable/load/next address). It fetches one instruction per PC value from instruction memory over a req/ack handshake and hands it to decode over valid/ready. It also arbitrates branch redirects from execute against sequential increment. It sits between the pc block, instruction memory and the decode stage.

Parameters:
WIDTH, 8, address width; must match the pc block's WIDTH.
IWIDTH, 8, instruction word width.
RESET_VEC, 0, address loaded into the PC after reset.
TIMEOUT, 16, cycles without mem_ack before a fetch error (FETCH_TIMEOUT_EN only); minimum 2.

Ports:
clk  in  1  clock, all state on rising edge.
reset_n  in  1  asynchronous reset, active-low.
run  in  1  fetch enable; low drains to HALT.
pc_adr  in  WIDTH  current PC value.
pc_enable  out  1  PC increment request.
pc_load  out  1  PC load request.
pc_nxt_adr  out  WIDTH  PC load value.
mem_req  out  1  instruction read request.
mem_adr  out  WIDTH  read address; equals pc_adr.
mem_ack  in  1  one-cycle read-data-valid strobe.
mem_rdata  in  IWIDTH  read data, valid with mem_ack.
instr_valid  out  1  instruction available to decode.
instr_data  out  IWIDTH  registered instruction.
instr_adr  out  WIDTH  address of instr_data.
instr_ready  in  1  decode accepts instruction.
br_valid  in  1  branch redirect request; held until br_ack.
br_target  in  WIDTH  branch destination.
br_ack  out  1  one-cycle branch acceptance.
halted  out  1  high in HALT state.
fetch_err  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (reset_n low, async): state INIT. All 1-bit outputs 0. instr_data, instr_adr 0. pc_nxt_adr = RESET_VEC. Reset mid-fetch abandons the fetch with no further mem_req.
- pc_load and pc_enable are never high in the same cycle. Load has priority.
- INIT (1 cycle): pc_load=1, pc_nxt_adr=RESET_VEC. Next state is FETCH if run, else HALT. br_valid is ignored.
- FETCH: mem_req=1, mem_adr=pc_adr. PC is not changed while waiting, so the address stays stable.
  - mem_ack without br_valid: register mem_rdata into instr_data and pc_adr into instr_adr, then go to ISSUE. instr_valid rises the cycle after ack.
  - mem_ack with br_valid: discard data, pc_load=1, pc_nxt_adr=br_target, br_ack=1, stay in FETCH. A new request goes out next cycle to br_target.
  - br_valid without mem_ack: not accepted; wait.
  - run low: the outstanding fetch completes normally; the check happens at ISSUE exit.
- ISSUE: instr_valid=1; instr_data and instr_adr are held stable until the handshake completes.
  - br_valid (regardless of instr_ready): pc_load=1, pc_nxt_adr=br_target, br_ack=1. If instr_ready is also high, the instruction counts as consumed; otherwise it is dropped. instr_valid goes low next cycle. Next state is FETCH if run, else HALT.
  - instr_ready without br_valid: pc_enable=1. Next state is FETCH if run, else HALT.
- HALT: halted=1, no mem_req, instr_valid=0.
  - br_valid: accepted (pc_load, br_ack), stay in HALT.
  - run high: go to FETCH next cycle.
- Back-to-back throughput: one instruction per 2 cycles plus memory latency, with mem_ack in the first FETCH cycle and instr_ready held high.
- PC wrap: all-ones increments to 0 with no special handling; instr_adr follows.
- br_ack is asserted only in a cycle where pc_load=1.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a counter runs while in FETCH and clears on state entry and on mem_ack. When the count reaches TIMEOUT with no ack:
  - fetch_err=1 (sticky until reset_n);
  - mem_req drops;
  - state goes to HALT and stays there regardless of run.
- Undefined: no counter is built, fetch_err is tied 0, and FETCH waits indefinitely.

Decomposition:
- Shared package fetch_seq_pkg:
  - state encoding constants ST_INIT, ST_FETCH, ST_ISSUE, ST_HALT (2-bit);
  - default RESET_VEC.
- One sub-module: fetch_timer, the timeout counter (TIMEOUT param; clear/run inputs, expired output). It is instantiated only under FETCH_TIMEOUT_EN.
- The FSM and output logic stay in fetch_seq.

Test Plan:
1. Release reset with run=1, RESET_VEC=0x10, mem_ack one cycle after req, instr_ready=1 -> pc_load in cycle 1; fetches at 0x10, 0x11, 0x12; instr_adr follows; pc_enable once per instruction.
2. In ISSUE with instr_adr=0x20, assert br_valid with br_target=0x40 and instr_ready=0 -> br_ack and pc_load same cycle, instruction dropped, next mem_adr=0x40.
3. br_valid held from the start of FETCH, mem_ack after 3 cycles -> br_ack only in the ack cycle, data discarded, instr_valid stays 0, refetch at br_target.
4. PC at 0xFF, instr_ready=1 -> next fetch at 0x00; run low during FETCH -> fetch completes, instruction issues, then HALT with halted=1 and no mem_req.
5. Pulse reset_n low mid-FETCH -> mem_req, instr_valid, br_ack low immediately (asynchronous); after release, INIT loads RESET_VEC.
6. With FETCH_TIMEOUT_EN, TIMEOUT=16, mem_ack never asserted -> fetch_err=1 after 16 FETCH cycles, HALT entered, run ignored until reset. Without the macro, fetch_err stays 0.
